mem_port_scheduler: RTL and testbench

- Shares the single external memory port between the core's data requester and its instruction-fetch requester.
- Arbitrates with data priority plus an anti-starvation bound, then registers the winning request into one output stage.
- Tracks outstanding reads in an in-order tag FIFO and routes each returning 64-bit beat back to the requester that issued it.
- Sits between the core and the endian controllers on the memory side.

---
 rtl/mem_port_scheduler_if.sv | 32 +++
 rtl/mem_port_scheduler.sv | 73 +++++++
 tb/tb_mem_port_scheduler.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_scheduler_if.sv
// mem_port_scheduler_if: core-side requesters, memory-side port and status of the memory port scheduler
interface mem_port_scheduler_if #(parameter int DEPTH = 4);
  logic                     iDATA_REQ, oDATA_LOCK, iDATA_RW, oDATA_VALID, iDATA_BUSY;
  logic [1:0]               iDATA_ORDER;
  logic [3:0]               iDATA_MASK;
  logic [31:0]              iDATA_ADDR, iDATA_DATA;
  logic [63:0]              oDATA_DATA;
  logic                     iINST_REQ, oINST_LOCK, oINST_VALID, iINST_BUSY;
  logic [31:0]              iINST_ADDR;
  logic [63:0]              oINST_DATA;
  logic                     oMEMORY_REQ, iMEMORY_LOCK, oMEMORY_RW, iMEMORY_VALID, oMEMORY_BUSY;
  logic [1:0]               oMEMORY_ORDER;
  logic [3:0]               oMEMORY_MASK;
  logic [31:0]              oMEMORY_ADDR, oMEMORY_DATA;
  logic [63:0]              iMEMORY_DATA;
  logic [$clog2(DEPTH):0]   oPENDING;
  logic                     oRETURN_ERROR;
  modport slave (
    input  iDATA_REQ, iDATA_ORDER, iDATA_MASK, iDATA_RW, iDATA_ADDR, iDATA_DATA, iDATA_BUSY,
    input  iINST_REQ, iINST_ADDR, iINST_BUSY, iMEMORY_LOCK, iMEMORY_VALID, iMEMORY_DATA,
    output oDATA_LOCK, oDATA_VALID, oDATA_DATA, oINST_LOCK, oINST_VALID, oINST_DATA,
    output oMEMORY_REQ, oMEMORY_ORDER, oMEMORY_MASK, oMEMORY_RW, oMEMORY_ADDR, oMEMORY_DATA,
    output oMEMORY_BUSY, oPENDING, oRETURN_ERROR
  );
  modport master (
    output iDATA_REQ, iDATA_ORDER, iDATA_MASK, iDATA_RW, iDATA_ADDR, iDATA_DATA, iDATA_BUSY,
    output iINST_REQ, iINST_ADDR, iINST_BUSY, iMEMORY_LOCK, iMEMORY_VALID, iMEMORY_DATA,
    input  oDATA_LOCK, oDATA_VALID, oDATA_DATA, oINST_LOCK, oINST_VALID, oINST_DATA,
    input  oMEMORY_REQ, oMEMORY_ORDER, oMEMORY_MASK, oMEMORY_RW, oMEMORY_ADDR, oMEMORY_DATA,
    input  oMEMORY_BUSY, oPENDING, oRETURN_ERROR
  );
endinterface

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: data/fetch arbitration onto one memory port with in-order read return routing
module mem_port_scheduler #(
  parameter int DEPTH          = 4,
  parameter int MAX_DATA_BURST = 4
) (
  input logic                 iCLOCK,
  input logic                 inRESET,
  mem_port_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0]    pend_cnt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [DEPTH-1:0] tags;
  logic [3:0]       burst_cnt;
  logic             ret_err;
  logic             can_load, full, empty, head, data_ok, inst_ok;
  logic             grant_data, grant_inst, push, pop;
  always_comb begin
    can_load   = !bus.oMEMORY_REQ || !bus.iMEMORY_LOCK;
    full       = pend_cnt == PW'(DEPTH);
    empty      = pend_cnt == '0;
    head       = tags[rd_ptr];
    data_ok    = bus.iDATA_REQ && can_load && (bus.iDATA_RW || !full);
    inst_ok    = bus.iINST_REQ && can_load && !full;
    grant_data = data_ok && !(inst_ok && burst_cnt == 4'(MAX_DATA_BURST));
    grant_inst = inst_ok && !grant_data;
    push       = grant_inst || (grant_data && !bus.iDATA_RW);
    pop        = bus.iMEMORY_VALID && !empty && !bus.oMEMORY_BUSY;
  end
  assign bus.oDATA_LOCK    = !grant_data;
  assign bus.oINST_LOCK    = !grant_inst;
  assign bus.oDATA_DATA    = bus.iMEMORY_DATA;
  assign bus.oINST_DATA    = bus.iMEMORY_DATA;
  assign bus.oDATA_VALID   = bus.iMEMORY_VALID && !empty && !head;
  assign bus.oINST_VALID   = bus.iMEMORY_VALID && !empty && head;
  assign bus.oMEMORY_BUSY  = !empty && (head ? bus.iINST_BUSY : bus.iDATA_BUSY);
  assign bus.oPENDING      = pend_cnt;
  assign bus.oRETURN_ERROR = ret_err;
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      {bus.oMEMORY_REQ, bus.oMEMORY_ORDER, bus.oMEMORY_MASK, bus.oMEMORY_RW,
       bus.oMEMORY_ADDR, bus.oMEMORY_DATA} <= 72'd0;
      pend_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tags      <= '0;
      burst_cnt <= '0;
      ret_err   <= 1'b0;
    end else begin
      if (grant_data)
        {bus.oMEMORY_REQ, bus.oMEMORY_ORDER, bus.oMEMORY_MASK, bus.oMEMORY_RW,
         bus.oMEMORY_ADDR, bus.oMEMORY_DATA} <= {1'b1, bus.iDATA_ORDER, bus.iDATA_MASK,
                                                 bus.iDATA_RW, bus.iDATA_ADDR, bus.iDATA_DATA};
      else if (grant_inst)
        {bus.oMEMORY_REQ, bus.oMEMORY_ORDER, bus.oMEMORY_MASK, bus.oMEMORY_RW,
         bus.oMEMORY_ADDR, bus.oMEMORY_DATA} <= {1'b1, 2'b10, 4'hF, 1'b0, bus.iINST_ADDR, 32'h0};
      else if (!bus.iMEMORY_LOCK)
        {bus.oMEMORY_REQ, bus.oMEMORY_ORDER, bus.oMEMORY_MASK, bus.oMEMORY_RW,
         bus.oMEMORY_ADDR, bus.oMEMORY_DATA} <= 72'd0;
      if (push) begin
        tags[wr_ptr] <= grant_inst;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      pend_cnt  <= pend_cnt + PW'(push) - PW'(pop);
      // the burst budget only runs while a fetch is actually waiting
      burst_cnt <= (!bus.iINST_REQ || grant_inst) ? 4'd0 :
                   (grant_data && burst_cnt != 4'(MAX_DATA_BURST)) ? burst_cnt + 4'd1 : burst_cnt;
      ret_err   <= bus.iMEMORY_VALID && empty;
    end
  end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb_mem_port_scheduler: scoreboard bench for stage contents, return routing and arbitration order
module tb_mem_port_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_port_scheduler_if #(.DEPTH(4)) bus();
  mem_port_scheduler #(.DEPTH(4), .MAX_DATA_BURST(4)) dut (.iCLOCK(clk), .inRESET(rst_n), .bus(bus.slave));
  int vectors = 0;
  int miscompares = 0;
  logic [70:0] stage_q[$];
  bit          route_q[$];
  bit          grant_log[$];
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_data(bit rw, logic [31:0] a, logic [31:0] d);
    bus.iDATA_REQ = 1'b1; bus.iDATA_RW = rw; bus.iDATA_ADDR = a; bus.iDATA_DATA = d;
    bus.iDATA_ORDER = 2'b01; bus.iDATA_MASK = 4'hC;
    #1 chk("data_accept", 128'(bus.oDATA_LOCK), 128'd0);
    step;
    bus.iDATA_REQ = 1'b0;
  endtask
  task automatic drive_inst(logic [31:0] a);
    bus.iINST_REQ = 1'b1; bus.iINST_ADDR = a;
    #1 chk("inst_accept", 128'(bus.oINST_LOCK), 128'd0);
    step;
    bus.iINST_REQ = 1'b0;
  endtask
  task automatic ret(logic [63:0] d, int n);
    bus.iMEMORY_VALID = 1'b1; bus.iMEMORY_DATA = d;
    repeat (n) step;
    bus.iMEMORY_VALID = 1'b0;
  endtask
  // scoreboard: accepted requests queue expected stage entries and return owners
  always @(negedge clk) begin
    if (!rst_n) begin
      stage_q.delete();
      route_q.delete();
    end else begin
      chk("pending", 128'(bus.oPENDING), 128'(route_q.size()));
      if (bus.oMEMORY_REQ && !bus.iMEMORY_LOCK) begin
        if (stage_q.size() == 0) chk("stage_unexpected", 128'(bus.oMEMORY_REQ), 128'd0);
        else chk("stage", 128'({bus.oMEMORY_ORDER, bus.oMEMORY_MASK, bus.oMEMORY_RW,
                                bus.oMEMORY_ADDR, bus.oMEMORY_DATA}), 128'(stage_q.pop_front()));
      end
      if (bus.iMEMORY_VALID) begin
        if (route_q.size() == 0) begin
          chk("untagged_valid", 128'({bus.oINST_VALID, bus.oDATA_VALID}), 128'd0);
          chk("untagged_busy", 128'(bus.oMEMORY_BUSY), 128'd0);
        end else begin
          chk("route", 128'({bus.oINST_VALID, bus.oDATA_VALID}), route_q[0] ? 128'd2 : 128'd1);
          chk("ret_busy", 128'(bus.oMEMORY_BUSY), 128'(route_q[0] ? bus.iINST_BUSY : bus.iDATA_BUSY));
          if (!(route_q[0] ? bus.iINST_BUSY : bus.iDATA_BUSY)) void'(route_q.pop_front());
        end
      end
      if (bus.iDATA_REQ && !bus.oDATA_LOCK) begin
        stage_q.push_back({bus.iDATA_ORDER, bus.iDATA_MASK, bus.iDATA_RW, bus.iDATA_ADDR, bus.iDATA_DATA});
        if (!bus.iDATA_RW) route_q.push_back(1'b0);
        grant_log.push_back(1'b0);
      end
      if (bus.iINST_REQ && !bus.oINST_LOCK) begin
        stage_q.push_back({2'b10, 4'hF, 1'b0, bus.iINST_ADDR, 32'h0});
        route_q.push_back(1'b1);
        grant_log.push_back(1'b1);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [9:0] exp_order;
    bus.iDATA_REQ = 0; bus.iDATA_ORDER = 0; bus.iDATA_MASK = 0; bus.iDATA_RW = 0;
    bus.iDATA_ADDR = 0; bus.iDATA_DATA = 0; bus.iDATA_BUSY = 0;
    bus.iINST_REQ = 0; bus.iINST_ADDR = 0; bus.iINST_BUSY = 0;
    bus.iMEMORY_LOCK = 0; bus.iMEMORY_VALID = 0; bus.iMEMORY_DATA = 0;
    step; step;
    rst_n = 1'b1;
    chk("rst_req", 128'(bus.oMEMORY_REQ), 128'd0);
    chk("rst_addr", 128'(bus.oMEMORY_ADDR), 128'd0);
    chk("rst_pending", 128'(bus.oPENDING), 128'd0);
    chk("rst_err", 128'(bus.oRETURN_ERROR), 128'd0);
    chk("rst_locks", 128'({bus.oDATA_LOCK, bus.oINST_LOCK}), 128'd3);
    // single read
    drive_data(1'b0, 32'h0000_1000, 32'h0);
    chk("sr_req", 128'(bus.oMEMORY_REQ), 128'd1);
    chk("sr_rw", 128'(bus.oMEMORY_RW), 128'd0);
    chk("sr_addr", 128'(bus.oMEMORY_ADDR), 128'h1000);
    chk("sr_pend1", 128'(bus.oPENDING), 128'd1);
    step;
    chk("sr_clear", 128'(bus.oMEMORY_REQ), 128'd0);
    bus.iMEMORY_VALID = 1'b1; bus.iMEMORY_DATA = 64'h1122334455667788;
    #1;
    chk("sr_valid", 128'({bus.oDATA_VALID, bus.oINST_VALID}), 128'd2);
    chk("sr_data", 128'(bus.oDATA_DATA), 128'h1122334455667788);
    step;
    bus.iMEMORY_VALID = 1'b0;
    chk("sr_pend0", 128'(bus.oPENDING), 128'd0);
    // starvation bound: data writes against continuous fetches
    grant_log.delete();
    bus.iDATA_REQ = 1'b1; bus.iDATA_RW = 1'b1; bus.iDATA_ADDR = 32'h500; bus.iDATA_DATA = 32'hA5A5;
    bus.iINST_REQ = 1'b1; bus.iINST_ADDR = 32'h800;
    repeat (10) step;
    bus.iDATA_REQ = 1'b0; bus.iINST_REQ = 1'b0;
    exp_order = 10'b1000010000;
    chk("starve_len", 128'(grant_log.size()), 128'd10);
    for (int k = 0; k < 10 && k < grant_log.size(); k++)
      chk($sformatf("starve_%0d", k), 128'(grant_log[k]), 128'(exp_order[k]));
    step;
    ret(64'h11, 2);
    chk("starve_drain", 128'(bus.oPENDING), 128'd0);
    // full FIFO
    for (int k = 0; k < 4; k++) drive_data(1'b0, 32'h2000 + 32'(k * 4), 32'h0);
    bus.iDATA_REQ = 1'b1; bus.iDATA_RW = 1'b0; bus.iDATA_ADDR = 32'h2010;
    #1;
    chk("full_lock", 128'(bus.oDATA_LOCK), 128'd1);
    chk("full_pend", 128'(bus.oPENDING), 128'd4);
    bus.iDATA_RW = 1'b1; bus.iDATA_DATA = 32'hCAFE;
    #1 chk("full_write", 128'(bus.oDATA_LOCK), 128'd0);
    step;
    bus.iDATA_RW = 1'b0; bus.iMEMORY_VALID = 1'b1; bus.iMEMORY_DATA = 64'h22;
    #1 chk("full_still_lock", 128'(bus.oDATA_LOCK), 128'd1);
    step;
    bus.iMEMORY_VALID = 1'b0;
    #1;
    chk("full_freed", 128'(bus.oDATA_LOCK), 128'd0);
    chk("full_pend3", 128'(bus.oPENDING), 128'd3);
    step;
    bus.iDATA_REQ = 1'b0;
    ret(64'h33, 4);
    chk("full_drain", 128'(bus.oPENDING), 128'd0);
    // interleaved routing with data-side backpressure
    drive_inst(32'h100);
    drive_data(1'b0, 32'h200, 32'h0);
    drive_inst(32'h104);
    step;
    bus.iMEMORY_VALID = 1'b1; bus.iMEMORY_DATA = 64'hAAAA;
    #1 chk("il_a_inst", 128'(bus.oINST_VALID), 128'd1);
    step;
    bus.iMEMORY_DATA = 64'hBBBB; bus.iDATA_BUSY = 1'b1;
    #1;
    chk("il_b_data", 128'(bus.oDATA_VALID), 128'd1);
    chk("il_b_busy", 128'(bus.oMEMORY_BUSY), 128'd1);
    step;
    chk("il_b_hold", 128'(bus.oPENDING), 128'd2);
    chk("il_c_blocked", 128'(bus.oINST_VALID), 128'd0);
    step;
    bus.iDATA_BUSY = 1'b0;
    #1 chk("il_b_free", 128'(bus.oMEMORY_BUSY), 128'd0);
    step;
    bus.iMEMORY_DATA = 64'hCCCC;
    #1 chk("il_c_inst", 128'(bus.oINST_VALID), 128'd1);
    step;
    bus.iMEMORY_VALID = 1'b0;
    chk("il_drain", 128'(bus.oPENDING), 128'd0);
    // memory lock holds the stage
    bus.iMEMORY_LOCK = 1'b1;
    drive_data(1'b1, 32'h300, 32'hDEADBEEF);
    bus.iDATA_REQ = 1'b1; bus.iDATA_RW = 1'b1; bus.iDATA_ADDR = 32'h304; bus.iDATA_DATA = 32'h12345678;
    bus.iINST_REQ = 1'b1; bus.iINST_ADDR = 32'h400;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("lk_locks", 128'({bus.oDATA_LOCK, bus.oINST_LOCK}), 128'd3);
      chk("lk_addr", 128'(bus.oMEMORY_ADDR), 128'h300);
      chk("lk_data", 128'(bus.oMEMORY_DATA), 128'hDEADBEEF);
      step;
    end
    bus.iMEMORY_LOCK = 1'b0;
    #1 chk("lk_release", 128'(bus.oDATA_LOCK), 128'd0);
    step;
    bus.iDATA_REQ = 1'b0;
    #1 chk("lk_inst_next", 128'(bus.oINST_LOCK), 128'd0);
    step;
    bus.iINST_REQ = 1'b0;
    step;
    ret(64'h44, 1);
    chk("lk_drain", 128'(bus.oPENDING), 128'd0);
    // reset with reads in flight
    for (int k = 0; k < 3; k++) drive_data(1'b0, 32'h600 + 32'(k * 8), 32'h0);
    step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("mr_pend", 128'(bus.oPENDING), 128'd0);
    chk("mr_req", 128'(bus.oMEMORY_REQ), 128'd0);
    bus.iMEMORY_VALID = 1'b1; bus.iMEMORY_DATA = 64'h55;
    #1;
    chk("mr_no_valid", 128'({bus.oDATA_VALID, bus.oINST_VALID}), 128'd0);
    step;
    bus.iMEMORY_VALID = 1'b0;
    chk("mr_err", 128'(bus.oRETURN_ERROR), 128'd1);
    step;
    chk("mr_err_pulse", 128'(bus.oRETURN_ERROR), 128'd0);
    step;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
